// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one SLL and one SRA shifter between two requesters,
// with a one-entry result buffer and saturating per-requester completion counters.
module shift_unit_arbiter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_op,
  input  logic [DATA_W-1:0]  req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [TAG_W-1:0]   req0_tag,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_op,
  input  logic [DATA_W-1:0]  req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic [TAG_W-1:0]   req1_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_id,
  output logic [TAG_W-1:0]   out_tag,
  output logic [CNT_W-1:0]   cnt0,
  output logic [CNT_W-1:0]   cnt1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_p0;
  logic               vld_p0;
  logic [DATA_W-1:0]  data_p0;
  logic               id_p0;
  logic [TAG_W-1:0]   tag_p0;
  logic               last_grant_p0;
  logic [CNT_W-1:0]   cnt0_p0;
  logic [CNT_W-1:0]   cnt1_p0;

  logic               drain;
  logic               can_accept;
  logic               grant_vld;
  logic               grant_id;
  logic               accept;
  logic               sel_op;
  logic [DATA_W-1:0]  sel_data;
  logic [SHAMT_W-1:0] sel_shamt;
  logic [TAG_W-1:0]   sel_tag;
  logic [DATA_W-1:0]  sll_res;
  logic [DATA_W-1:0]  sra_res;
  logic [DATA_W-1:0]  shift_res;

  function automatic logic [DATA_W-1:0] shift_sll(input logic [DATA_W-1:0]  d,
                                                  input logic [SHAMT_W-1:0] s);
    return d << s;
  endfunction

  function automatic logic [DATA_W-1:0] shift_sra(input logic signed [DATA_W-1:0] d,
                                                  input logic [SHAMT_W-1:0]       s);
    logic signed [DATA_W-1:0] r;
    r = d >>> s;
    return $unsigned(r);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign drain      = vld_p0 & out_ready;
  assign can_accept = ~reset & ((state_p0 == EMPTY) | drain);

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_vld = req0_valid | req1_valid;
    grant_id  = 1'b0;
    if (req0_valid & req1_valid)
      grant_id = ~last_grant_p0;
    else if (req1_valid)
      grant_id = 1'b1;
  end

  assign req0_ready = can_accept & grant_vld & ~grant_id;
  assign req1_ready = can_accept & grant_vld & grant_id;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    sel_op    = req0_op;
    sel_data  = req0_data;
    sel_shamt = req0_shamt;
    sel_tag   = req0_tag;
    if (grant_id) begin
      sel_op    = req1_op;
      sel_data  = req1_data;
      sel_shamt = req1_shamt;
      sel_tag   = req1_tag;
    end
  end

  assign sll_res   = shift_sll(sel_data, sel_shamt);
  assign sra_res   = shift_sra(sel_data, sel_shamt);
  assign shift_res = sel_op ? sra_res : sll_res;

  // Stage p0: result buffer, owner, tag and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p0      <= EMPTY;
      vld_p0        <= 1'b0;
      data_p0       <= '0;
      id_p0         <= 1'b0;
      tag_p0        <= '0;
      last_grant_p0 <= 1'b1;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (accept) begin
            state_p0 <= FULL;
            vld_p0   <= 1'b1;
          end
        end
        FULL: begin
          if (drain & ~accept) begin
            state_p0 <= EMPTY;
            vld_p0   <= 1'b0;
          end
        end
        default: begin
          state_p0 <= EMPTY;
          vld_p0   <= 1'b0;
        end
      endcase
      if (accept) begin
        data_p0       <= shift_res;
        id_p0         <= grant_id;
        tag_p0        <= sel_tag;
        last_grant_p0 <= grant_id;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt0_p0 <= '0;
      cnt1_p0 <= '0;
    end else if (drain) begin
      if (id_p0)
        cnt1_p0 <= sat_inc(cnt1_p0);
      else
        cnt0_p0 <= sat_inc(cnt0_p0);
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign out_id    = id_p0;
  assign out_tag   = tag_p0;
  assign cnt0      = cnt0_p0;
  assign cnt1      = cnt1_p0;

endmodule

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
Shares a single arithmetic-right shifter and a single logical-left shifter between two requesters, e.g. the execute-stage ALU and the multi-cycle multiply/divide sequencer. Requests use valid/ready handshakes and are arbitrated round-robin. The granted request is shifted and its result is captured in a one-entry output buffer with its own valid/ready handshake. The block also keeps per-requester completion counters for performance monitoring.

Parameters:
DATA_W, 32, operand/result width; fixed at 32 to match the shared shifters.
SHAMT_W, 5, shift amount width.
TAG_W, 4, opaque requester tag carried alongside the result.
CNT_W, 16, width of each completion counter.

Ports:
clock  in  1  single clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
req0_valid  in  1  requester 0 has a request.
req0_ready  out  1  requester 0 request is accepted this cycle.
req0_op  in  1  0 = SLL, 1 = SRA.
req0_data  in  DATA_W  operand.
req0_shamt  in  SHAMT_W  shift amount.
req0_tag  in  TAG_W  tag.
req1_valid, req1_ready, req1_op, req1_data, req1_shamt, req1_tag  same as requester 0, for requester 1.
out_valid  out  1  the result buffer holds a result.
out_ready  in  1  the consumer takes the result.
out_data  out  DATA_W  shifted result.
out_id  out  1  index of the requester that owns the result.
out_tag  out  TAG_W  tag of the result.
cnt0  out  CNT_W  results delivered to requester 0, saturating.
cnt1  out  CNT_W  results delivered to requester 1, saturating.

Behaviour:
- Reset values (clock edge with reset=1): out_valid=0, out_data=0, out_id=0, out_tag=0, cnt0=cnt1=0, round-robin last_grant=1, FSM=EMPTY.
- The reset value of last_grant means requester 0 wins the first tie.
- FSM states:
  - EMPTY: buffer free.
  - FULL: out_valid=1.
- FSM transitions:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain with accept in the same cycle (back-to-back).
  - FULL -> FULL (hold) when out_ready=0.
- drain = out_valid & out_ready.
- can_accept = (FSM==EMPTY) | drain.
- Arbitration (combinational):
  - Only one requester valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant.
- reqN_ready = can_accept & grant==N. Ready is combinational.
- Ready never asserts for a requester that is not valid.
- Accept = reqN_valid & reqN_ready. On accept:
  - The granted operand is shifted by the shared shifters in the same cycle.
  - The result selected by op is registered into out_data.
  - out_id=N, out_tag=reqN_tag, out_valid=1 on the next edge.
  - last_grant=N.
- Latency: exactly 1 cycle from accept to out_valid. Throughput: 1 result/cycle while out_ready=1.
- Shift rules:
  - SLL fills with zeros.
  - SRA replicates data[31].
  - shamt=0 passes the operand through unchanged.
  - Only the low 5 bits of shamt are used; no modulo beyond 5 bits.
- While FULL and out_ready=0:
  - out_data, out_id and out_tag are stable.
  - Both ready signals are 0.
  - last_grant does not change.
- Counters: on drain, cnt[out_id] += 1, saturating at all-ones.
- Simultaneous drain and accept: the counter increments for the drained result, and the buffer loads the new result.
- Reset mid-operation: any buffered result is discarded with no drain. Requests presented in the reset cycle are not accepted (ready=0 while reset=1).

Test Plan:
- Single request: req0 SRA, data 0x80000000, shamt 4, out_ready=1 -> req0_ready=1 in the request cycle; next cycle out_valid=1, out_data=0xF8000000, out_id=0, tag echoed; cnt0=1 after drain.
- Fairness: both requesters held valid for 6 cycles, out_ready=1 -> grant order 0,1,0,1,0,1; cnt0=cnt1=3.
- Backpressure: buffer FULL with 0x0000ABCD, out_ready=0 for 3 cycles with both requesters valid -> both readies 0 and the output stable; raise out_ready -> drain and accept in the same cycle, and the next result appears one cycle later.
- Shift edges: SLL 0x00000001 shamt 31 -> 0x80000000; SRA 0x80000000 shamt 31 -> 0xFFFFFFFF; SRA 0x7FFFFFFF shamt 31 -> 0x00000000; SLL/SRA 0x12345678 shamt 0 -> 0x12345678.
- Reset mid-operation: assert reset while FULL with out_ready=0 -> next cycle out_valid=0, out_data=0, cnt0=cnt1=0; after release, a tie grants requester 0 first.
- Counter saturation: preload via 2^CNT_W-1 drains to requester 1 (CNT_W=4 in a reduced-width run: 15 drains), then one more drain -> cnt1 stays 0xF.
